// File: rtl/tube_scan_ctrl.sv
// tube_scan_ctrl: binary-to-BCD converter (serial double dabble) driving a
// multiplexed 7-segment display with leading-zero blanking, overflow dashes
// and a frame-based blink.
module tube_scan_ctrl #(
   parameter int DIGITS    = 2,
   parameter int BIN_W     = 6,
   parameter int SCAN_DIV  = 1000,
   parameter int BLINK_DIV = 50
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BIN_W-1:0]  count,
   input  logic              load,
   input  logic              blink_en,
   output logic              busy,
   output logic [7:0]        seg,
   output logic [DIGITS-1:0] dig_sel
);

   // Decimal digits needed for the largest BIN_W-bit value (2^BIN_W - 1).
   function automatic int dec_digits(input int w);
      longint v;
      int     d;
      v = (longint'(1) << w) - longint'(1);
      d = 1;
      for (int i = 0; i < 20; i++) begin
         if (v >= 10) begin
            v = v / 10;
            d = d + 1;
         end
      end
      return d;
   endfunction

   localparam int NBCD  = dec_digits(BIN_W);
   localparam int BCD_W = 4 * NBCD;
   localparam int SR_W  = BCD_W + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift.
   function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] v);
      logic [SR_W-1:0] a;
      a = v;
      for (int i = 0; i < NBCD; i++) begin
         if (a[BIN_W + 4*i +: 4] >= 4'd5)
            a[BIN_W + 4*i +: 4] = a[BIN_W + 4*i +: 4] + 4'd3;
      end
      return a << 1;
   endfunction

   // Active-high segment pattern for one decimal digit; dp is always off.
   function automatic logic [7:0] seg_code(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'h3F;
         4'd1:    s = 8'h06;
         4'd2:    s = 8'h5B;
         4'd3:    s = 8'h4F;
         4'd4:    s = 8'h66;
         4'd5:    s = 8'h6D;
         4'd6:    s = 8'h7D;
         4'd7:    s = 8'h07;
         4'd8:    s = 8'h7F;
         4'd9:    s = 8'h6F;
         default: s = 8'h00;
      endcase
      return s;
   endfunction

   // Pattern for digit position idx of a BCD value: dashes when the value does
   // not fit in DIGITS, blank above the highest nonzero digit, digit 0 always lit.
   function automatic logic [7:0] slot_pattern(input logic [BCD_W-1:0] bcd,
                                               input logic [IDX_W-1:0] idx);
      logic       ovf;
      logic       upper_nz;
      logic [3:0] nib;
      ovf      = 1'b0;
      upper_nz = 1'b0;
      nib      = 4'd0;
      for (int i = DIGITS; i < NBCD; i++) begin
         if (bcd[4*i +: 4] != 4'd0) ovf = 1'b1;
      end
      for (int i = 0; i < NBCD; i++) begin
         if (i == int'(idx)) nib = bcd[4*i +: 4];
         if ((i >= int'(idx)) && (bcd[4*i +: 4] != 4'd0)) upper_nz = 1'b1;
      end
      if (ovf)
         return 8'h40;
      else if ((idx != '0) && !upper_nz)
         return 8'h00;
      else
         return seg_code(nib);
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

   state_t            state, state_nx;
   logic              cap_en, shift_en, done_en;
   logic [SR_W-1:0]   conv_sr;
   logic [CNT_W-1:0]  shift_cnt;
   logic [BCD_W-1:0]  disp, disp_nx;

   logic [PRE_W-1:0]  presc, presc_nx;
   logic              presc_wrap, frame_end, blink_flip;
   logic [IDX_W-1:0]  dig_idx, dig_idx_nx;
   logic [FRM_W-1:0]  frame_cnt, frame_cnt_nx;
   logic              phase_on, phase_nx;
   logic [7:0]        slot_pat, slot_nx;

   // Conversion FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // Next-state and control decode; loads are only accepted in IDLE.
   always_comb begin
      state_nx = state;
      cap_en   = 1'b0;
      shift_en = 1'b0;
      done_en  = 1'b0;
      busy     = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (load) begin
               cap_en   = 1'b1;
               state_nx = S_CONV;
            end
         end
         S_CONV: begin
            shift_en = 1'b1;
            if (shift_cnt == CNT_W'(BIN_W - 1)) state_nx = S_DONE;
         end
         S_DONE: begin
            done_en  = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Shift register and display register; reset drops any partial result.
   always_ff @(posedge clk) begin
      if (!rst) begin
         shift_cnt <= '0;
         disp      <= '0;
      end else begin
         if (cap_en) begin
            conv_sr   <= {{BCD_W{1'b0}}, count};
            shift_cnt <= '0;
         end else if (shift_en) begin
            conv_sr   <= dabble_step(conv_sr);
            shift_cnt <= shift_cnt + CNT_W'(1);
         end
         disp <= disp_nx;
      end
   end

   // Scan timing, blink phase and the pattern for the upcoming digit slot.
   always_comb begin
      disp_nx      = done_en ? conv_sr[BIN_W +: BCD_W] : disp;
      presc_wrap   = (presc == PRE_W'(SCAN_DIV - 1));
      frame_end    = presc_wrap && (dig_idx == IDX_W'(DIGITS - 1));
      blink_flip   = frame_end && (frame_cnt == FRM_W'(BLINK_DIV - 1));
      presc_nx     = presc_wrap ? '0 : presc + PRE_W'(1);
      dig_idx_nx   = dig_idx;
      frame_cnt_nx = frame_cnt;
      if (presc_wrap)
         dig_idx_nx = (dig_idx == IDX_W'(DIGITS - 1)) ? '0 : dig_idx + IDX_W'(1);
      if (frame_end)
         frame_cnt_nx = blink_flip ? '0 : frame_cnt + FRM_W'(1);
      phase_nx = blink_flip ? ~phase_on : phase_on;
      // Content is latched only at slot starts, using the same-edge display value.
      slot_nx  = presc_wrap ? slot_pattern(disp_nx, dig_idx_nx) : slot_pat;
   end

   // Registered scan outputs; seg always matches the digit selected with it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         presc     <= '0;
         dig_idx   <= '0;
         frame_cnt <= '0;
         phase_on  <= 1'b1;
         slot_pat  <= 8'h3F;
         seg       <= 8'h3F;
         dig_sel   <= DIGITS'(1);
      end else begin
         presc     <= presc_nx;
         dig_idx   <= dig_idx_nx;
         frame_cnt <= frame_cnt_nx;
         phase_on  <= phase_nx;
         slot_pat  <= slot_nx;
         seg       <= (blink_en && !phase_nx) ? 8'h00 : slot_nx;
         dig_sel   <= DIGITS'(1) << dig_idx_nx;
      end
   end

endmodule
